// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle 16x16 shift-add multiplier (low 16 bits of the product) that
// performs all of its arithmetic on a shared, combinational Hack-style ALU.
// One ALU operation is issued per clock, and its result is captured at the
// end of that same cycle. The block owns the ALU while busy is high.
//
// Per multiplier bit, lowest bit first:
//   TEST  : mplier & mask      -> zr says whether the bit is clear
//   ADD   : prod + mcand       (only when the bit is set)
//   DBL_M : mcand + mcand      (shift the multiplicand left)
//   DBL_K : mask + mask        (shift the mask; zr ends the loop)
//
// Optional feature macro: MUL_EARLY_EXIT_EN
//   When defined, DBL_M jumps straight to DONE once the doubled multiplicand
//   is zero, because no remaining bit can change prod. When undefined, the
//   latency is fixed at 49 + popcount(b) cycles after the accept edge.
//
// Ports
//   clk, reset         : clock; synchronous active-high reset
//   start              : multiply request, sampled only in IDLE
//   a, b               : multiplicand / multiplier, captured on accept
//   busy               : high in every state except IDLE
//   done               : one-cycle pulse in the DONE state
//   product            : result register, held until the next accept
//   alu_x, alu_y       : ALU operands
//   alu_zx .. alu_no   : ALU control bits
//   alu_out, alu_zr    : ALU result and zero flag
// ---------------------------------------------------------------------------
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_DBL_M,
    S_DBL_K,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] mask;
  logic [15:0] prod;

  assign product = prod;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // flop samples the values from before the edge, regardless of the order
  // in which the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next-state and ALU command decode
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case
    // statement, so a path that does not assign it cannot infer a latch.
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    alu_x     = '0;
    alu_y     = '0;
    alu_zx    = 1'b0;
    alu_nx    = 1'b0;
    alu_zy    = 1'b0;
    alu_ny    = 1'b0;
    alu_f     = 1'b0;
    alu_no    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_TEST;
      end

      S_TEST: begin
        // x & y with all controls clear; zr set means the bit is 0.
        alu_x     = mplier;
        alu_y     = mask;
        state_nxt = alu_zr ? S_DBL_M : S_ADD;
      end

      S_ADD: begin
        alu_x     = prod;
        alu_y     = mcand;
        alu_f     = 1'b1;
        state_nxt = S_DBL_M;
      end

      S_DBL_M: begin
        alu_x     = mcand;
        alu_y     = mcand;
        alu_f     = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
        // A zero multiplicand contributes nothing to any later ADD.
        state_nxt = alu_zr ? S_DONE : S_DBL_K;
`else
        state_nxt = S_DBL_K;
`endif
      end

      S_DBL_K: begin
        // The mask wraps to zero only after its single 1 passes bit 15.
        alu_x     = mask;
        alu_y     = mask;
        alu_f     = 1'b1;
        state_nxt = alu_zr ? S_DONE : S_TEST;
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: loaded on accept, otherwise updated from alu_out
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      mask   <= '0;
      prod   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            mask   <= 16'h0001;
            prod   <= '0;
          end
        end
        S_ADD:   prod  <= alu_out;
        S_DBL_M: mcand <= alu_out;
        S_DBL_K: mask  <= alu_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Bench for alu_mul_seq. A behavioural Hack ALU is attached to the ALU port
// of the DUT. Expected products come from plain multiplication, and expected
// completion cycles come from the per-bit cost rules (TEST, optional ADD,
// DBL_M, DBL_K). The optional MUL_EARLY_EXIT_EN exit is modelled as well.
// ---------------------------------------------------------------------------
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;

  int checks;
  int failures;

  alu_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_zx  (alu_zx),
    .alu_nx  (alu_nx),
    .alu_zy  (alu_zy),
    .alu_ny  (alu_ny),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out),
    .alu_zr  (alu_zr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack ALU behaviour
  logic [15:0] hx;
  logic [15:0] hy;
  logic [15:0] hr;
  always_comb begin
    hx = alu_zx ? 16'h0000 : alu_x;
    hx = alu_nx ? ~hx : hx;
    hy = alu_zy ? 16'h0000 : alu_y;
    hy = alu_ny ? ~hy : hy;
    hr = alu_f ? (hx + hy) : (hx & hy);
    hr = alu_no ? ~hr : hr;
    alu_out = hr;
    alu_zr  = (hr == 16'h0000);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle in which DONE is expected, counting the accept edge as cycle 0.
  function automatic int model_latency(input logic [15:0] ma, input logic [15:0] mb);
    int c;
    int dbl_m;
    c = 1;
    for (int i = 0; i < 16; i++) begin
      dbl_m = c + 1 + int'(mb[i]);
`ifdef MUL_EARLY_EXIT_EN
      if (((32'(ma) << (i + 1)) & 32'h0000_FFFF) == 32'h0) return dbl_m + 1;
`endif
      c = dbl_m + 2;
    end
    return c;
  endfunction

  function automatic logic [15:0] model_product(input logic [15:0] ma, input logic [15:0] mb);
    logic [31:0] full;
    full = 32'(ma) * 32'(mb);
    return full[15:0];
  endfunction

  // Run one multiply. When inject is set, extra starts with other operands
  // are pulsed while busy (cycles 5 and 20), and afterwards the bench watches
  // for any spurious second done pulse.
  task automatic run_mul(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic [15:0] ep, input int ec, input bit inject);
    int cyc;
    bit got;
    int extra_done;
    @(negedge clk);
    a_i   = ta;
    b_i   = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = 16'($urandom);
    b_i   = 16'($urandom);
    cyc   = 1;
    got   = 1'b0;
    while (cyc < 200 && !got) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (inject && (cyc == 5 || cyc == 20)) begin
          start = 1'b1;
          a_i   = 16'h5A5A;
          b_i   = 16'hFFFF;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_latency"}, 32'(cyc), 32'(ec));
      check({name, "_product"}, 32'(product), 32'(ep));
      check({name, "_busy_in_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({name, "_done_pulse_len"}, {30'd0, done, busy}, 32'd0);
      check({name, "_product_hold"}, 32'(product), 32'(ep));
      if (inject) begin
        extra_done = 0;
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (done || busy) extra_done++;
        end
        check({name, "_no_second_run"}, 32'(extra_done), 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[5];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b1;
    a_i      = 16'h0005;
    b_i      = 16'h0005;

    // Reset held for two cycles with start asserted: reset wins.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_product", 32'(product), 32'd0);
      check("reset_alu_idle",
            {alu_x[7:0], alu_y[7:0], 10'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}
              | 32'(alu_x) | 32'(alu_y), 32'd0);
    end
    start = 1'b0;
    reset = 1'b0;

    // Directed vectors
    vecs[0] = '{16'h0003, 16'h0005, 16'h000F};
    vecs[1] = '{16'h8000, 16'h0001, 16'h8000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[3] = '{16'h1234, 16'h0000, 16'h0000};
    vecs[4] = '{16'h0007, 16'h0009, 16'h003F};
    for (int i = 0; i < 5; i++) begin
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod,
              model_latency(vecs[i].a, vecs[i].b), 1'b0);
    end

    // Starts pulsed while busy are ignored.
    run_mul("ignore_start", 16'h000B, 16'h000D, 16'h008F,
            model_latency(16'h000B, 16'h000D), 1'b1);

    // Reset in the middle of a multiply aborts it without a done pulse.
    @(negedge clk);
    a_i   = 16'h0007;
    b_i   = 16'h0009;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    begin
      int spurious;
      spurious = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done) spurious++;
      end
      check("abort_no_done", 32'(spurious), 32'd0);
    end
    run_mul("after_abort", 16'h0007, 16'h0009, 16'h003F,
            model_latency(16'h0007, 16'h0009), 1'b0);

    // Randomized operands against the reference model
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 5 == 1) ra = ra & 16'hFF00;
      if (i % 5 == 2) rb = rb & 16'h00F0;
      run_mul($sformatf("rand%0d", i), ra, rb, model_product(ra, rb),
              model_latency(ra, rb), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
